// File: rtl/fifo_pkg.sv
// Shared FIFO constants and helpers: threshold defaults and pointer width.
package fifo_pkg;

    // Almost-empty fires at or below this many words by default.
    localparam int unsigned AEMPTY_TH_DEFAULT = 2;
    // Almost-full fires this many words short of full by default.
    localparam int unsigned AFULL_MARGIN = 2;

    // Pointers carry one extra bit so full and empty are distinguishable.
    function automatic int unsigned ptr_width(input int unsigned addrsize);
        return addrsize + 1;
    endfunction

    function automatic int unsigned afull_default(input int unsigned addrsize);
        return (32'd1 << addrsize) - AFULL_MARGIN;
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// Dual-port storage: synchronous write port, registered read port with enable.
module fifo_ram #(
    parameter int unsigned DATASIZE = 8,
    parameter int unsigned ADDRSIZE = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                we,
    input  logic [ADDRSIZE-1:0] waddr,
    input  logic [DATASIZE-1:0] wdata,
    input  logic                re,
    input  logic [ADDRSIZE-1:0] raddr,
    output logic [DATASIZE-1:0] rdata
);

    localparam int unsigned DEPTH = 1 << ADDRSIZE;

    logic [DATASIZE-1:0] mem [DEPTH];

    // Write port; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read register: loads only on an accepted read, otherwise holds.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO: pointers, occupancy, registered status flags and sticky errors.
module sync_fifo
    import fifo_pkg::*;
#(
    parameter int unsigned DATASIZE  = 8,
    parameter int unsigned ADDRSIZE  = 4,
    parameter int unsigned AFULL_TH  = afull_default(ADDRSIZE),
    parameter int unsigned AEMPTY_TH = AEMPTY_TH_DEFAULT
) (
    input  logic                wclk,
    input  logic                wrst,
    input  logic                winc,
    input  logic [DATASIZE-1:0] wdata,
    input  logic                rinc,
    output logic [DATASIZE-1:0] rdata,
    output logic                rvalid,
    output logic                wfull,
    output logic                rempty,
    output logic                walmost_full,
    output logic                ralmost_empty,
    output logic [ADDRSIZE:0]   count,
    output logic                overflow,
    output logic                underflow
);

    localparam int unsigned PW    = ptr_width(ADDRSIZE);
    localparam int unsigned DEPTH = 1 << ADDRSIZE;

    localparam logic [PW-1:0] DEPTH_C  = PW'(DEPTH);
    localparam logic [PW-1:0] AFULL_C  = PW'(AFULL_TH);
    localparam logic [PW-1:0] AEMPTY_C = PW'(AEMPTY_TH);

    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [PW-1:0] count_d;
    logic          wr_en, rd_en;

    // Accept/reject decisions use the registered flags, so a full FIFO rejects a
    // write even when a read frees a slot on the same edge (and vice versa).
    always_comb begin
        wr_en   = winc & ~wfull;
        rd_en   = rinc & ~rempty;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        if (wr_en) begin
            wptr_d = wptr_q + PW'(1);
        end
        if (rd_en) begin
            rptr_d = rptr_q + PW'(1);
        end
        count_d = wptr_d - rptr_d;
    end

    // Pointer, occupancy, flag and error registers; flags come from next-state count.
    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            wptr_q        <= '0;
            rptr_q        <= '0;
            count         <= '0;
            rvalid        <= 1'b0;
            wfull         <= 1'b0;
            rempty        <= 1'b1;
            walmost_full  <= 1'b0;
            ralmost_empty <= 1'b1;
            overflow      <= 1'b0;
            underflow     <= 1'b0;
        end else begin
            wptr_q        <= wptr_d;
            rptr_q        <= rptr_d;
            count         <= count_d;
            rvalid        <= rd_en;
            wfull         <= (count_d == DEPTH_C);
            rempty        <= (count_d == '0);
            walmost_full  <= (count_d >= AFULL_C);
            ralmost_empty <= (count_d <= AEMPTY_C);
            overflow      <= overflow | (winc & wfull);
            underflow     <= underflow | (rinc & rempty);
        end
    end

    fifo_ram #(
        .DATASIZE(DATASIZE),
        .ADDRSIZE(ADDRSIZE)
    ) u_ram (
        .clk  (wclk),
        .rst  (wrst),
        .we   (wr_en),
        .waddr(wptr_q[ADDRSIZE-1:0]),
        .wdata(wdata),
        .re   (rd_en),
        .raddr(rptr_q[ADDRSIZE-1:0]),
        .rdata(rdata)
    );

endmodule

// File: doc/sync_fifo.md
SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 The module SHALL have parameter DATASIZE, default 8, meaning data word width in bits.
REQ-002 The module SHALL have parameter ADDRSIZE, default 4, meaning address bits, so DEPTH = 2**ADDRSIZE.
REQ-003 The module SHALL have parameter AFULL_TH, default DEPTH-2, meaning almost-full threshold in words.
REQ-004 The module SHALL have parameter AEMPTY_TH, default 2, meaning almost-empty threshold in words.
REQ-005 The module SHALL have port wclk, input, 1 bit, the single clock, with all logic on its rising edge.
REQ-006 The module SHALL have port wrst, input, 1 bit, reset, which is asynchronous and active-high.
REQ-007 The module SHALL have port winc, input, 1 bit, meaning write request.
REQ-008 The module SHALL have port wdata, input, DATASIZE bits, meaning write data.
REQ-009 The module SHALL have port rinc, input, 1 bit, meaning read request.
REQ-010 The module SHALL have port rdata, output, DATASIZE bits, meaning registered read data.
REQ-011 The module SHALL have port rvalid, output, 1 bit, meaning rdata holds a newly read word.
REQ-012 The module SHALL have ports wfull and rempty, outputs, 1 bit each, meaning full and empty status.
REQ-013 The module SHALL have ports walmost_full and ralmost_empty, outputs, 1 bit each, meaning threshold flags.
REQ-014 The module SHALL have port count, output, ADDRSIZE+1 bits, meaning current occupancy (0..DEPTH).
REQ-015 The module SHALL have ports overflow and underflow, outputs, 1 bit each, meaning sticky error flags.

Function
REQ-016 A write SHALL be accepted when winc=1 and wfull=0, storing wdata at wptr[ADDRSIZE-1:0] and incrementing wptr.
REQ-017 A read SHALL be accepted when rinc=1 and rempty=0, loading mem[rptr[ADDRSIZE-1:0]] into rdata on that edge, incrementing rptr, and setting rvalid=1 for one cycle (latency 1).
REQ-018 wptr and rptr SHALL be ADDRSIZE+1-bit binary counters that wrap modulo 2**(ADDRSIZE+1).
REQ-019 count SHALL equal wptr-rptr modulo 2**(ADDRSIZE+1) and be registered.
REQ-020 Status outputs SHALL be registered and derived from the next-state count: rempty=(count==0), wfull=(count==DEPTH), walmost_full=(count>=AFULL_TH), ralmost_empty=(count<=AEMPTY_TH).
REQ-021 On a simultaneous accepted read and write, count SHALL be unchanged and both pointers SHALL advance.
REQ-022 When full, a write SHALL be rejected even if a read is accepted in the same cycle.
REQ-023 When empty, a read SHALL be rejected even if a write is accepted in the same cycle, so no write-through bypass is provided.
REQ-024 A rejected write (winc=1, wfull=1) SHALL set overflow, which stays set until reset, and SHALL leave memory and pointers unchanged.
REQ-025 A rejected read (rinc=1, rempty=1) SHALL set underflow, which stays set until reset, and SHALL leave rdata unchanged with rvalid=0.
REQ-026 rdata SHALL hold its last value when no read is accepted.

Reset
REQ-027 Asserting wrst SHALL immediately clear wptr, rptr, count, rdata, rvalid, wfull, walmost_full, overflow and underflow to 0, and set rempty=1 and ralmost_empty=1.
REQ-028 Reset SHALL NOT clear memory contents, and data in flight SHALL be discarded on reset mid-operation.
REQ-029 The first accepted operation SHALL occur on the first rising edge after wrst deasserts.

Structure
REQ-030 Threshold defaults and the pointer-width function ADDRSIZE+1 SHALL live in a shared package, fifo_pkg.
REQ-031 Storage SHALL be a sub-module, fifo_ram, a dual-port array with a synchronous write port and a registered read port with enable.
REQ-032 Pointer, count, flag and error logic SHALL reside in sync_fifo.

Verification
REQ-033 Reset, then write 0x01..0x10 (16 words) -> wfull=1 and count=16 after the 16th edge; walmost_full=1 from count=14.
REQ-034 From full, 16 reads -> rdata=0x01..0x10 in order, each one cycle after rinc with rvalid=1; finally rempty=1 and count=0.
REQ-035 From count=5, winc=rinc=1 for 40 cycles -> count stays 5, pointers wrap, and data order is preserved.
REQ-036 Full with winc=rinc=1 -> read accepted, write rejected, overflow=1, count=15.
REQ-037 Empty with rinc=1, wdata=0xAA, winc=1 -> underflow=1, rvalid=0, count=1; the next read returns 0xAA.
REQ-038 Assert wrst at count=7 mid-stream -> all flags and count return to reset values with no clock edge required.
